hv_bundler_unit: RTL and testbench

Bundling (majority) stage that sits directly downstream of the hypervector ALU PE. It consumes a stream of HVs over a valid/ready handshake and keeps one signed saturating counter per dimension. When a bundle is marked complete, it presents the binarized majority HV downstream over a second valid/ready handshake, then clears itself for the next bundle.

---
 rtl/hv_bundler_unit_pkg.sv | 12 +
 rtl/hv_bundler_unit_if.sv | 29 ++
 rtl/hv_bundler_cnt.sv | 45 ++++
 rtl/hv_bundler_unit.sv | 88 ++++++++
 tb/tb_hv_bundler_unit.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/hv_bundler_unit_pkg.sv
// Shared types and default widths for the hypervector bundling stage.
package hv_bundler_unit_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    OUT   = 1'b1
  } bundler_state_t;

  localparam int BundlerCounterWidth = 8;
  localparam int BundlerCountWidth   = 16;

endpackage

// File: rtl/hv_bundler_unit_if.sv
// Input and output HV streams of the bundler, with the running bundle count.
// slave is the bundler side, master is the upstream/downstream side.
interface hv_bundler_unit_if
  import hv_bundler_unit_pkg::*;
#(
  parameter int HVDimension = 512,
  parameter int CountWidth  = BundlerCountWidth
);

  logic [HVDimension-1:0] hv_i;
  logic                   hv_valid_i;
  logic                   hv_last_i;
  logic                   hv_ready_o;
  logic [HVDimension-1:0] hv_o;
  logic                   hv_valid_o;
  logic                   hv_ready_i;
  logic [CountWidth-1:0]  count_o;

  modport slave (
    input  hv_i, hv_valid_i, hv_last_i, hv_ready_i,
    output hv_ready_o, hv_o, hv_valid_o, count_o
  );

  modport master (
    output hv_i, hv_valid_i, hv_last_i, hv_ready_i,
    input  hv_ready_o, hv_o, hv_valid_o, count_o
  );

endinterface

// File: rtl/hv_bundler_cnt.sv
// One signed per-dimension vote counter. Saturates when HV_BUNDLER_SAT_EN is
// defined, otherwise wraps two's complement.
module hv_bundler_cnt
  import hv_bundler_unit_pkg::*;
#(
  parameter int Width = BundlerCounterWidth
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic up,
  output logic pos
);

  localparam logic signed [Width-1:0] One = {{(Width-1){1'b0}}, 1'b1};
`ifdef HV_BUNDLER_SAT_EN
  localparam logic signed [Width-1:0] MaxVal = {1'b0, {(Width-1){1'b1}}};
  localparam logic signed [Width-1:0] MinVal = {1'b1, {(Width-1){1'b0}}};
`endif

  logic signed [Width-1:0] value;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (en) begin
`ifdef HV_BUNDLER_SAT_EN
      if (up) begin
        if (value != MaxVal) value <= value + One;
      end else begin
        if (value != MinVal) value <= value - One;
      end
`else
      value <= up ? value + One : value - One;
`endif
    end
  end

  // Strictly positive: a tie at zero votes 0.
  assign pos = !value[Width-1] && (|value);

endmodule

// File: rtl/hv_bundler_unit.sv
// Majority bundler: accumulates HVs into per-bit vote counters and presents the
// binarized bundle downstream. HV_BUNDLER_SAT_EN selects saturating counters.
//
// state | meaning
// ACCUM | accepting input HVs, counters updating
// OUT   | bundle presented on hv_o, waiting for downstream ready
module hv_bundler_unit
  import hv_bundler_unit_pkg::*;
#(
  parameter int HVDimension  = 512,
  parameter int CounterWidth = BundlerCounterWidth,
  parameter int CountWidth   = BundlerCountWidth
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clr_i,
  hv_bundler_unit_if.slave    bus
);

  bundler_state_t         state, state_nxt;
  logic                   in_fire;
  logic                   out_fire;
  logic                   cnt_clr;
  logic [HVDimension-1:0] pos;
  logic [CountWidth-1:0]  count;

  // Clear wins over both handshakes, so a coincident input beat is dropped.
  assign in_fire  = bus.hv_valid_i && (state == ACCUM) && !clr_i;
  assign out_fire = (state == OUT) && bus.hv_ready_i;
  assign cnt_clr  = clr_i || out_fire;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ACCUM;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clr_i) begin
      state_nxt = ACCUM;
    end else begin
      case (state)
        ACCUM:   if (in_fire && bus.hv_last_i) state_nxt = OUT;
        OUT:     if (out_fire) state_nxt = ACCUM;
        default: state_nxt = ACCUM;
      endcase
    end
  end

  always_comb begin
    bus.hv_ready_o = 1'b0;
    bus.hv_valid_o = 1'b0;
    case (state)
      ACCUM:   bus.hv_ready_o = 1'b1;
      OUT:     bus.hv_valid_o = 1'b1;
      default: ;
    endcase
  end

  for (genvar i = 0; i < HVDimension; i++) begin : g_cnt
    hv_bundler_cnt #(.Width(CounterWidth)) u_cnt (
      .clk (clk_i),
      .rst (rst_i),
      .clr (cnt_clr),
      .en  (in_fire),
      .up  (bus.hv_i[i]),
      .pos (pos[i])
    );
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count <= '0;
    end else if (cnt_clr) begin
      count <= '0;
    end else if (in_fire) begin
`ifdef HV_BUNDLER_SAT_EN
      if (!(&count)) count <= count + CountWidth'(1);
`else
      count <= count + CountWidth'(1);
`endif
    end
  end

  assign bus.hv_o    = pos;
  assign bus.count_o = count;

endmodule

// File: tb/tb_hv_bundler_unit.sv
// Directed bench for hv_bundler_unit at HVDimension=8, CounterWidth=4.
module tb_hv_bundler_unit;

  logic clk = 1'b0;
  logic rst;
  logic clr;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  hv_bundler_unit_if #(.HVDimension(8), .CountWidth(16)) bus ();

  hv_bundler_unit #(
    .HVDimension (8),
    .CounterWidth(4),
    .CountWidth  (16)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .clr_i(clr),
    .bus  (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] v, input logic last);
    bus.hv_i       = v;
    bus.hv_valid_i = 1'b1;
    bus.hv_last_i  = last;
    tick();
    bus.hv_valid_i = 1'b0;
    bus.hv_last_i  = 1'b0;
  endtask

  task automatic drain();
    bus.hv_ready_i = 1'b1;
    tick();
    bus.hv_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (bus.hv_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.hv_valid_o); end
    checks++; if (bus.hv_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.hv_ready_o); end
    checks++; if (bus.hv_o !== 8'h00) begin errors++; $display("FAIL reset_hv: got %h want 00", bus.hv_o); end
    checks++; if (bus.count_o !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.count_o); end
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++; if (bus.hv_ready_o !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b want 1", bus.hv_ready_o); end
  endtask

  task automatic test_majority();
    send(8'hF0, 1'b0);
    send(8'hCC, 1'b0);
    send(8'hAA, 1'b1);
    checks++; if (bus.hv_valid_o !== 1'b1) begin errors++; $display("FAIL maj_valid: got %b want 1", bus.hv_valid_o); end
    checks++; if (bus.hv_ready_o !== 1'b0) begin errors++; $display("FAIL maj_ready: got %b want 0", bus.hv_ready_o); end
    checks++; if (bus.hv_o !== 8'hE8) begin errors++; $display("FAIL maj_hv: got %h want e8", bus.hv_o); end
    checks++; if (bus.count_o !== 16'd3) begin errors++; $display("FAIL maj_count: got %0d want 3", bus.count_o); end
    drain();
    checks++; if (bus.hv_ready_o !== 1'b1) begin errors++; $display("FAIL maj_drain_ready: got %b want 1", bus.hv_ready_o); end
    checks++; if (bus.hv_valid_o !== 1'b0) begin errors++; $display("FAIL maj_drain_valid: got %b want 0", bus.hv_valid_o); end
    checks++; if (bus.count_o !== 16'd0) begin errors++; $display("FAIL maj_drain_count: got %0d want 0", bus.count_o); end
  endtask

  task automatic test_tie();
    send(8'hFF, 1'b0);
    send(8'h00, 1'b1);
    checks++; if (bus.hv_o !== 8'h00) begin errors++; $display("FAIL tie_hv: got %h want 00", bus.hv_o); end
    checks++; if (bus.count_o !== 16'd2) begin errors++; $display("FAIL tie_count: got %0d want 2", bus.count_o); end
    drain();
  endtask

  task automatic test_overflow();
    logic [7:0] exp_hv;
`ifdef HV_BUNDLER_SAT_EN
    exp_hv = 8'hFF;
`else
    exp_hv = 8'h00;
`endif
    for (int i = 0; i < 10; i++) send(8'hFF, i == 9);
    checks++; if (bus.hv_o !== exp_hv) begin errors++; $display("FAIL ovf_hv: got %h want %h", bus.hv_o, exp_hv); end
    checks++; if (bus.count_o !== 16'd10) begin errors++; $display("FAIL ovf_count: got %0d want 10", bus.count_o); end
    drain();
  endtask

  task automatic test_stall();
    send(8'h3C, 1'b1);
    checks++; if (bus.count_o !== 16'd1) begin errors++; $display("FAIL single_count: got %0d want 1", bus.count_o); end
    bus.hv_i      = 8'hFF;
    bus.hv_last_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.hv_valid_i = (i % 2 == 0);
      tick();
      checks++; if (bus.hv_o !== 8'h3C) begin errors++; $display("FAIL stall_hv[%0d]: got %h want 3c", i, bus.hv_o); end
      checks++; if (bus.hv_ready_o !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d]: got %b want 0", i, bus.hv_ready_o); end
      checks++; if (bus.count_o !== 16'd1) begin errors++; $display("FAIL stall_count[%0d]: got %0d want 1", i, bus.count_o); end
    end
    bus.hv_valid_i = 1'b0;
    bus.hv_last_i  = 1'b0;
    drain();
    checks++; if (bus.hv_ready_o !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %b want 1", bus.hv_ready_o); end
    checks++; if (bus.count_o !== 16'd0) begin errors++; $display("FAIL stall_release_count: got %0d want 0", bus.count_o); end
  endtask

  task automatic test_back_to_back();
    send(8'h0F, 1'b1);
    checks++; if (bus.hv_o !== 8'h0F) begin errors++; $display("FAIL b2b_hv: got %h want 0f", bus.hv_o); end
    checks++; if (bus.count_o !== 16'd1) begin errors++; $display("FAIL b2b_count: got %0d want 1", bus.count_o); end
    drain();
  endtask

  task automatic test_clear();
    send(8'hF0, 1'b0);
    checks++; if (bus.count_o !== 16'd1) begin errors++; $display("FAIL clr_pre_count: got %0d want 1", bus.count_o); end
    bus.hv_i       = 8'h0F;
    bus.hv_valid_i = 1'b1;
    clr            = 1'b1;
    tick();
    clr            = 1'b0;
    bus.hv_valid_i = 1'b0;
    checks++; if (bus.count_o !== 16'd0) begin errors++; $display("FAIL clr_count: got %0d want 0", bus.count_o); end
    checks++; if (bus.hv_ready_o !== 1'b1) begin errors++; $display("FAIL clr_ready: got %b want 1", bus.hv_ready_o); end
    send(8'h81, 1'b1);
    checks++; if (bus.hv_o !== 8'h81) begin errors++; $display("FAIL clr_restart_hv: got %h want 81", bus.hv_o); end
    checks++; if (bus.count_o !== 16'd1) begin errors++; $display("FAIL clr_restart_count: got %0d want 1", bus.count_o); end
    clr            = 1'b1;
    bus.hv_ready_i = 1'b1;
    tick();
    clr            = 1'b0;
    bus.hv_ready_i = 1'b0;
    checks++; if (bus.hv_valid_o !== 1'b0) begin errors++; $display("FAIL clr_out_valid: got %b want 0", bus.hv_valid_o); end
    checks++; if (bus.hv_o !== 8'h00) begin errors++; $display("FAIL clr_out_hv: got %h want 00", bus.hv_o); end
  endtask

  task automatic test_async_reset();
    send(8'hC3, 1'b1);
    checks++; if (bus.hv_valid_o !== 1'b1) begin errors++; $display("FAIL arst_pre_valid: got %b want 1", bus.hv_valid_o); end
    #1 rst = 1'b1;
    #1;
    checks++; if (bus.hv_valid_o !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b want 0", bus.hv_valid_o); end
    checks++; if (bus.hv_ready_o !== 1'b1) begin errors++; $display("FAIL arst_ready: got %b want 1", bus.hv_ready_o); end
    checks++; if (bus.hv_o !== 8'h00) begin errors++; $display("FAIL arst_hv: got %h want 00", bus.hv_o); end
    checks++; if (bus.count_o !== 16'd0) begin errors++; $display("FAIL arst_count: got %0d want 0", bus.count_o); end
    rst = 1'b0;
    tick();
    send(8'h5A, 1'b1);
    checks++; if (bus.hv_o !== 8'h5A) begin errors++; $display("FAIL arst_next_hv: got %h want 5a", bus.hv_o); end
    checks++; if (bus.hv_valid_o !== 1'b1) begin errors++; $display("FAIL arst_next_valid: got %b want 1", bus.hv_valid_o); end
    drain();
  endtask

  initial begin
    rst            = 1'b1;
    clr            = 1'b0;
    bus.hv_i       = '0;
    bus.hv_valid_i = 1'b0;
    bus.hv_last_i  = 1'b0;
    bus.hv_ready_i = 1'b0;
    test_reset();
    test_majority();
    test_tie();
    test_overflow();
    test_stall();
    test_back_to_back();
    test_clear();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
